// File: rtl/regfile_wr_arb_pkg.sv
// Shared regfile defines and helpers for the regfile write arbiter.
package regfile_wr_arb_pkg;

    localparam logic RstEnable    = 1'b1;
    localparam logic RstDisable   = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam int unsigned RegWidth     = 32;
    localparam int unsigned RegAddrWidth = 5;
    localparam int unsigned StatW        = 16;

    typedef logic [RegWidth-1:0]     RegBus;
    typedef logic [RegAddrWidth-1:0] RegAddrBus;

    localparam RegAddrBus NOPRegAddr = RegAddrBus'(0);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // Increment that sticks at all-ones.
    function automatic logic [StatW-1:0] sat_inc(input logic [StatW-1:0] v);
        return (v == {StatW{1'b1}}) ? v : v + StatW'(1);
    endfunction

endpackage

// File: rtl/regfile_wr_arb_rr_arb2.sv
// Two-way round-robin arbiter: priority pointer flop plus combinational grants.
module rr_arb2
    import regfile_wr_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic hold,
    output logic gnt0_c,
    output logic gnt1_c,
    output logic contend_c
);

    port_e ptr_q;

    always_comb begin
        gnt0_c    = 1'b0;
        gnt1_c    = 1'b0;
        contend_c = 1'b0;
        if ((rst != RstEnable) && !hold) begin
            if (valid0 && valid1) begin
                contend_c = 1'b1;
                gnt0_c    = (ptr_q == PORT0);
                gnt1_c    = (ptr_q == PORT1);
            end else begin
                gnt0_c = valid0;
                gnt1_c = valid1;
            end
        end
    end

    // Pointer only advances past the winner of a contended cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            ptr_q <= PORT0;
        end else if (contend_c) begin
            ptr_q <= (ptr_q == PORT0) ? PORT1 : PORT0;
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// Arbitrates two regfile write requesters onto one registered write port.
// Optional per-port grant and conflict counters: define REGFILE_WR_ARB_STATS_EN.
module regfile_wr_arb
    import regfile_wr_arb_pkg::*;
#(
    parameter int unsigned DATA_W = RegWidth,
    parameter int unsigned ADDR_W = RegAddrWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              hold,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
`ifdef REGFILE_WR_ARB_STATS_EN
    ,
    output logic [StatW-1:0]  grant_cnt0,
    output logic [StatW-1:0]  grant_cnt1,
    output logic [StatW-1:0]  conflict_cnt
`endif
);

    logic              gnt0_c;
    logic              gnt1_c;
    logic              contend_c;
    logic              hs_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_data_c;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .hold      (hold),
        .gnt0_c    (gnt0_c),
        .gnt1_c    (gnt1_c),
        .contend_c (contend_c)
    );

    assign req0_ready = gnt0_c;
    assign req1_ready = gnt1_c;

    // Grants already imply valid, so a grant is a handshake.
    always_comb begin
        hs_c       = gnt0_c | gnt1_c;
        sel_addr_c = req0_addr;
        sel_data_c = req0_data;
        if (gnt1_c) begin
            sel_addr_c = req1_addr;
            sel_data_c = req1_data;
        end
    end

    // Writes to the NOP register complete the handshake but never assert we.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            we    <= WriteDisable;
            waddr <= '0;
            wdata <= '0;
        end else if (hs_c) begin
            we    <= (sel_addr_c != ADDR_W'(NOPRegAddr)) ? WriteEnable : WriteDisable;
            waddr <= sel_addr_c;
            wdata <= sel_data_c;
        end else begin
            we    <= WriteDisable;
        end
    end

`ifdef REGFILE_WR_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            grant_cnt0   <= '0;
            grant_cnt1   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (gnt0_c)    grant_cnt0   <= sat_inc(grant_cnt0);
            if (gnt1_c)    grant_cnt1   <= sat_inc(grant_cnt1);
            if (contend_c) conflict_cnt <= sat_inc(conflict_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Self-checking bench for regfile_wr_arb: directed scenarios plus randomized traffic
// against a behavioural model. Define REGFILE_WR_ARB_STATS_EN to also check counters.
module tb_regfile_wr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, hold;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef REGFILE_WR_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

    regfile_wr_arb dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .hold       (hold),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata)
`ifdef REGFILE_WR_ARB_STATS_EN
        ,
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1),
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: who has priority, what the write port must show next.
    int          m_prio;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          e_r0, e_r1;
    int          m_c0, m_c1, m_cf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bump(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        m_prio = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
        m_c0 = 0; m_c1 = 0; m_cf = 0;
    endtask

    task automatic drive(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                         input bit h);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        hold = h;
    endtask

    task automatic idle();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
    endtask

    // One clock: compare everything against the model, then advance the model across the edge.
    task automatic cyc();
        bit hs0, hs1;
        #1;
        if (rst) model_reset();
        e_r0 = 0; e_r1 = 0;
        if (!rst && !hold) begin
            if (req0_valid && req1_valid) begin
                e_r0 = (m_prio == 0);
                e_r1 = (m_prio == 1);
            end else begin
                e_r0 = req0_valid;
                e_r1 = req1_valid;
            end
        end
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("we", we, m_we);
        if (m_we || rst) begin
            chk("waddr", waddr, m_waddr);
            chk("wdata", wdata, m_wdata);
        end
`ifdef REGFILE_WR_ARB_STATS_EN
        chk("grant_cnt0", grant_cnt0, m_c0);
        chk("grant_cnt1", grant_cnt1, m_c1);
        chk("conflict_cnt", conflict_cnt, m_cf);
`endif
        @(posedge clk);
        if (!rst) begin
            hs0 = req0_valid && e_r0;
            hs1 = req1_valid && e_r1;
            if (hs0 || hs1) begin
                m_we = hs1 ? (req1_addr != 0) : (req0_addr != 0);
                if (m_we) begin
                    m_waddr = hs1 ? req1_addr : req0_addr;
                    m_wdata = hs1 ? req1_data : req0_data;
                end
            end else begin
                m_we = 0;
            end
            if (req0_valid && req1_valid && !hold) begin
                m_prio = 1 - m_prio;
                m_cf = bump(m_cf);
            end
            if (hs0) m_c0 = bump(m_c0);
            if (hs1) m_c1 = bump(m_c1);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int          exp_g [4];
        logic [4:0]  exp_a [4];
        exp_g = '{0, 1, 0, 1};
        exp_a = '{5'd31, 5'd1, 5'd31, 5'd1};

        rst = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        cyc();
        #1;
        chk("rst_we", we, 1'b0);
        chk("rst_waddr", waddr, 5'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
        cyc();
        rst = 1'b0;

        // Single port write
        drive(1, 5'd2, 32'h9399, 0, 5'd0, 32'd0, 0);
        #1 chk("single_ready0", req0_ready, 1'b1);
        cyc();
        idle();
        #1;
        chk("single_we", we, 1'b1);
        chk("single_waddr", waddr, 5'd2);
        chk("single_wdata", wdata, 32'h9399);
        cyc();
        #1 chk("single_we_drop", we, 1'b0);
        cyc();

        // Continuous contention alternates starting at port 0
        do_reset();
        drive(1, 5'd31, 32'h3312, 1, 5'd1, 32'h0001, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_grant1", req1_ready, exp_g[i] == 1);
            chk("rr_grant0", req0_ready, exp_g[i] == 0);
            if (i > 0) begin
                chk("rr_we", we, 1'b1);
                chk("rr_waddr", waddr, exp_a[i-1]);
            end
            cyc();
        end
        idle();
        #1;
        chk("rr_last_we", we, 1'b1);
        chk("rr_last_waddr", waddr, 5'd1);
        cyc();

        // NOP register address
        drive(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF, 0);
        #1 chk("zero_ready1", req1_ready, 1'b1);
        cyc();
        idle();
        #1 chk("zero_we", we, 1'b0);
        cyc();

        // Hold blocks grants, in-flight write still issues, pointer kept
        do_reset();
        drive(1, 5'd7, 32'h77, 0, 5'd0, 32'd0, 0);
        cyc();
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 1);
        #1;
        chk("hold_ready", {req0_ready, req1_ready}, 2'b00);
        chk("hold_inflight_we", we, 1'b1);
        chk("hold_inflight_waddr", waddr, 5'd7);
        cyc();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold_we", we, 1'b0);
            chk("hold_ready2", {req0_ready, req1_ready}, 2'b00);
            cyc();
        end
        hold = 1'b0;
        #1 chk("hold_release_grant", {req0_ready, req1_ready}, 2'b10);
        cyc();
        idle();
        cyc();

        // Reset arriving between grant edge and issue
        do_reset();
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0);
        cyc();
        drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 0);
        cyc();
        rst = 1'b1;
        #1;
        chk("midrst_we", we, 1'b0);
        chk("midrst_ready", {req0_ready, req1_ready}, 2'b00);
        cyc();
        cyc();
        rst = 1'b0;
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0);
        #1 chk("midrst_ptr0", {req0_ready, req1_ready}, 2'b10);
        cyc();
        idle();
        cyc();

`ifdef REGFILE_WR_ARB_STATS_EN
        do_reset();
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0);
        repeat (5) cyc();
        drive(1, 5'd5, 32'h55, 0, 5'd0, 32'd0, 0);
        repeat (2) cyc();
        idle();
        cyc();
        chk("stats_cnt0", grant_cnt0, 16'd5);
        chk("stats_cnt1", grant_cnt1, 16'd2);
        chk("stats_conflict", conflict_cnt, 16'd5);
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] a0, a1;
            a0 = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            a1 = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive($urandom_range(0, 3) != 0, a0, $urandom,
                  $urandom_range(0, 3) != 0, a1, $urandom,
                  $urandom_range(0, 4) == 0);
            if (rst) rst = ($urandom_range(0, 1) == 0);
            else     rst = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
